// File: rtl/alu_bist_core_if.sv
`timescale 1ns/1ps
// Signal bundle between the system controller (master) and alu_bist_core (slave).
// pass/fail exist only when BIST_SIG_CHECK_EN is defined.
interface alu_bist_core_if;
    logic       start;
    logic [7:0] func_a;
    logic [7:0] func_b;
    logic [2:0] func_op;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       mode;
    logic       load;
    logic       capture;
    logic       done;
    logic [7:0] lfsr_out;
    logic [7:0] signature;
`ifdef BIST_SIG_CHECK_EN
    logic       pass;
    logic       fail;

    modport master (
        output start, func_a, func_b, func_op,
        input  alu_result, alu_carry, mode, load, capture, done, lfsr_out, signature,
        input  pass, fail
    );

    modport slave (
        input  start, func_a, func_b, func_op,
        output alu_result, alu_carry, mode, load, capture, done, lfsr_out, signature,
        output pass, fail
    );
`else
    modport master (
        output start, func_a, func_b, func_op,
        input  alu_result, alu_carry, mode, load, capture, done, lfsr_out, signature
    );

    modport slave (
        input  start, func_a, func_b, func_op,
        output alu_result, alu_carry, mode, load, capture, done, lfsr_out, signature
    );
`endif
endinterface

// File: rtl/alu_bist_core.sv
`timescale 1ns/1ps
// 8-bit ALU slice with built-in self test (pattern LFSR, MISR, controller FSM).
// Optional signature compare with pass/fail outputs: define BIST_SIG_CHECK_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | mission mode, all control outputs low, waits for start
// ST_LOAD | one cycle: seed LFSR, clear MISR, clear capture counter
// ST_RUN  | capture PATTERN_COUNT patterns into the MISR
// ST_DONE | signature frozen, done high; start relaunches the test
module alu_bist_core #(
    parameter logic [7:0] SEED          = 8'hAA,
    parameter logic [7:0] TEST_B        = 8'h0F,
    parameter logic [2:0] TEST_OP       = 3'b000,
    parameter int         PATTERN_COUNT = 16,
    parameter logic [7:0] GOLDEN_SIG    = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    alu_bist_core_if.slave bus
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] LAST_CNT = 8'(PATTERN_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] misr_q, misr_d;

    logic       mode_s, load_s, capture_s, done_s;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_res;
    logic       alu_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'h00;
            lfsr_q  <= SEED_EFF;
            misr_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_LOAD;
            ST_LOAD: begin
                cnt_d   = 8'h00;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + 8'h01;
                if (cnt_q == LAST_CNT) state_d = ST_DONE;
            end
            ST_DONE: if (bus.start) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mode_s    = 1'b0;
        load_s    = 1'b0;
        capture_s = 1'b0;
        done_s    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                mode_s = 1'b1;
                load_s = 1'b1;
            end
            ST_RUN: begin
                mode_s    = 1'b1;
                capture_s = 1'b1;
            end
            ST_DONE: done_s = 1'b1;
            default: ;
        endcase
    end

    // Both registers use x^8+x^6+x^5+x^4+1; the MISR also folds in the ALU result.
    always_comb begin
        lfsr_d = lfsr_q;
        misr_d = misr_q;
        if (load_s) begin
            lfsr_d = SEED_EFF;
            misr_d = 8'h00;
        end else if (capture_s) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            misr_d = {misr_q[6:0], misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3]} ^ alu_res;
        end
    end

    always_comb begin
        alu_a  = mode_s ? lfsr_q  : bus.func_a;
        alu_b  = mode_s ? TEST_B  : bus.func_b;
        alu_op = mode_s ? TEST_OP : bus.func_op;
    end

    always_comb begin
        alu_res = 8'h00;
        alu_c   = 1'b0;
        case (alu_op)
            3'b000: {alu_c, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: {alu_c, alu_res} = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010: alu_res = alu_a & alu_b;
            3'b011: alu_res = alu_a | alu_b;
            3'b100: alu_res = alu_a ^ alu_b;
            3'b101: alu_res = ~alu_a;
            3'b110: begin
                alu_res = {alu_a[6:0], 1'b0};
                alu_c   = alu_a[7];
            end
            3'b111: begin
                alu_res = {1'b0, alu_a[7:1]};
                alu_c   = alu_a[0];
            end
            default: ;
        endcase
    end

    assign bus.alu_result = alu_res;
    assign bus.alu_carry  = alu_c;
    assign bus.mode       = mode_s;
    assign bus.load       = load_s;
    assign bus.capture    = capture_s;
    assign bus.done       = done_s;
    assign bus.lfsr_out   = lfsr_q;
    assign bus.signature  = misr_q;

`ifdef BIST_SIG_CHECK_EN
    assign bus.pass = done_s & (misr_q == GOLDEN_SIG);
    assign bus.fail = done_s & (misr_q != GOLDEN_SIG);
`endif

endmodule

// File: tb/tb_alu_bist_core.sv
`timescale 1ns/1ps
// Bench for alu_bist_core: random mission-mode operands and full BIST runs
// checked against a behavioural ALU/signature model.
module tb_alu_bist_core;

    localparam logic [7:0] T_SEED   = 8'hAA;
    localparam logic [7:0] T_B      = 8'h0F;
    localparam int         T_OP     = 0;
    localparam int         N        = 16;
    localparam logic [7:0] T_GOLDEN = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_bist_core_if bus();

    alu_bist_core #(
        .SEED(T_SEED), .TEST_B(T_B), .TEST_OP(3'(T_OP)),
        .PATTERN_COUNT(N), .GOLDEN_SIG(T_GOLDEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] pat [0:N];
    logic [7:0] sig [0:N];

    function automatic logic [8:0] ref_alu(input int a, input int b, input int op);
        int r;
        int c;
        c = 0;
        r = 0;
        case (op)
            0: begin r = a + b; c = (r > 255) ? 1 : 0; r = r % 256; end
            1: begin c = (a < b) ? 1 : 0; r = (a - b + 256) % 256; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin c = (a >= 128) ? 1 : 0; r = (a * 2) % 256; end
            default: begin c = a % 2; r = a / 2; end
        endcase
        return 9'(c * 256 + r);
    endfunction

    // One step of a Fibonacci shift register with taps x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] poly_step(input logic [7:0] x);
        int fb;
        fb = $countones(x & 8'hB8) % 2;
        return 8'((int'(x) * 2) % 256 + fb);
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic m, input logic l,
                              input logic c, input logic d);
        check({tag, ".mode"},    9'(bus.mode),    9'(m));
        check({tag, ".load"},    9'(bus.load),    9'(l));
        check({tag, ".capture"}, 9'(bus.capture), 9'(c));
        check({tag, ".done"},    9'(bus.done),    9'(d));
    endtask

    task automatic mission_check(input string tag, input int a, input int b, input int op);
        logic [8:0] exp;
        bus.func_a  = 8'(a);
        bus.func_b  = 8'(b);
        bus.func_op = 3'(op);
        #1;
        exp = ref_alu(a, b, op);
        check({tag, ".result"}, 9'(bus.alu_result), 9'(exp[7:0]));
        check({tag, ".carry"},  9'(bus.alu_carry),  9'(exp[8]));
    endtask

    task automatic mission_random(input string tag);
        mission_check(tag, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 7)));
    endtask

    task automatic run_bist(input string tag, output logic [7:0] fsig);
        logic [8:0] exp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_ctrl({tag, ".load_cycle"}, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            bus.func_a  = 8'($urandom);
            bus.func_b  = 8'($urandom);
            bus.func_op = 3'($urandom);
            bus.start   = (i < N - 1) ? 1'($urandom) : 1'b0;
            tick();
            exp = ref_alu(int'(pat[i]), int'(T_B), T_OP);
            check_ctrl($sformatf("%s.run%0d", tag, i), 1'b1, 1'b0, 1'b1, 1'b0);
            check($sformatf("%s.lfsr%0d", tag, i), 9'(bus.lfsr_out), 9'(pat[i]));
            check($sformatf("%s.sig%0d", tag, i), 9'(bus.signature), 9'(sig[i]));
            check($sformatf("%s.alu%0d", tag, i), {bus.alu_carry, bus.alu_result}, exp);
`ifdef BIST_SIG_CHECK_EN
            check($sformatf("%s.passfail%0d", tag, i), 9'({bus.pass, bus.fail}), 9'd0);
`endif
            if (i == 0) check({tag, ".lfsr_first"}, 9'(bus.lfsr_out), 9'h0AA);
            if (i == 1) begin
                check({tag, ".lfsr_second"}, 9'(bus.lfsr_out), 9'h055);
                check({tag, ".sig_after1"},  9'(bus.signature), 9'h0B9);
            end
            if (i == 2) begin
                check({tag, ".lfsr_third"}, 9'(bus.lfsr_out), 9'h0AB);
                check({tag, ".sig_after2"}, 9'(bus.signature), 9'h016);
            end
        end
        bus.start = 1'b0;
        tick();
        check_ctrl({tag, ".done_cycle"}, 1'b0, 1'b0, 1'b0, 1'b1);
        check({tag, ".final_sig"},  9'(bus.signature), 9'(sig[N]));
        check({tag, ".final_lfsr"}, 9'(bus.lfsr_out),  9'(pat[N]));
`ifdef BIST_SIG_CHECK_EN
        check({tag, ".pass"}, 9'(bus.pass), 9'(sig[N] == T_GOLDEN));
        check({tag, ".fail"}, 9'(bus.fail), 9'(sig[N] != T_GOLDEN));
`endif
        fsig = bus.signature;
    endtask

    task automatic check_reset_vals(input string tag);
        check_ctrl(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, ".lfsr"}, 9'(bus.lfsr_out),  9'h0AA);
        check({tag, ".sig"},  9'(bus.signature), 9'h000);
`ifdef BIST_SIG_CHECK_EN
        check({tag, ".passfail"}, 9'({bus.pass, bus.fail}), 9'd0);
`endif
    endtask

    logic [7:0] first_sig;
    logic [7:0] again_sig;
    logic [7:0] after_rst_sig;

    initial begin
        bus.start   = 1'b0;
        bus.func_a  = 8'h00;
        bus.func_b  = 8'h00;
        bus.func_op = 3'b000;

        pat[0] = T_SEED;
        sig[0] = 8'h00;
        for (int i = 0; i < N; i++) begin
            logic [8:0] r;
            r          = ref_alu(int'(pat[i]), int'(T_B), T_OP);
            sig[i + 1] = poly_step(sig[i]) ^ r[7:0];
            pat[i + 1] = poly_step(pat[i]);
        end

        // Held in reset while start toggles.
        for (int i = 0; i < 4; i++) begin
            bus.start = ~bus.start;
            tick();
            check_reset_vals($sformatf("reset%0d", i));
        end
        bus.start = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_vals("idle_after_reset");

        mission_check("mission_add", 8'hAA, 8'h0F, 0);
        mission_check("mission_sub", 8'h05, 8'h07, 1);
        mission_check("mission_shl", 8'h81, 8'h00, 6);
        mission_check("mission_shr", 8'h81, 8'h00, 7);
        mission_check("mission_not", 8'h3C, 8'h00, 5);
        mission_check("mission_addwrap", 8'hFF, 8'h01, 0);
        for (int i = 0; i < 24; i++) mission_random($sformatf("mission_rand%0d", i));

        run_bist("run1", first_sig);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_ctrl($sformatf("done_sticky%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
            check($sformatf("done_sig%0d", i), 9'(bus.signature), 9'(sig[N]));
            mission_random($sformatf("done_mission%0d", i));
        end

        run_bist("run2", again_sig);
        check("restart_same_sig", 9'(again_sig), 9'(first_sig));

        // Abort mid-run with an asynchronous reset.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("midrun_capturing", 9'(bus.capture), 9'd1);
        #2 rst = 1'b0;
        #1;
        check_reset_vals("async_abort");
        for (int i = 0; i < 3; i++) begin
            bus.start = ~bus.start;
            tick();
            check_reset_vals($sformatf("abort_hold%0d", i));
        end
        bus.start = 1'b0;
        #3 rst = 1'b1;
        tick();
        check_reset_vals("abort_released");

        run_bist("run3", after_rst_sig);
        check("after_abort_sig", 9'(after_rst_sig), 9'(sig[N]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
